pipe_if_stage: RTL

- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the decode stage.
- Owns the PC register and next-PC selection, and drives a handshaked instruction-memory port that tolerates wait states.
- Provides the IF/ID pipeline register (dinst, dpc4, dvalid) consumed by decode.
- Honours decode stall, holds a returned instruction while stalled, and applies branch/jump redirects from decode.

---
 rtl/pipe_if_stage.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pipe_if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, handshaked imem port and IF/ID register.
// Define IF_DELAY_SLOT_EN for MIPS delay-slot semantics; by default the slot after a taken redirect is squashed.
module pipe_if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic [1:0]  pcsource,
   input  logic [31:0] bpc,
   input  logic [31:0] rpc,
   input  logic [31:0] jpc,
   input  logic        id_stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   output logic [31:0] dinst,
   output logic [31:0] dpc4,
   output logic        dvalid,
   output logic        if_busy
);

`ifdef IF_DELAY_SLOT_EN
   localparam logic SQUASH = 1'b0;
`else
   localparam logic SQUASH = 1'b1;
`endif

   typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt, pc4;
   logic [31:0] tgt_raw, target;
   logic [31:0] redir_tgt;
   logic        redir_pend, pend_set;
   logic        complete, consume, accept, redirect, discard;
   logic        load_mem, load_hold, to_hold;
   logic [31:0] hold_inst_p1, hold_pc4_p1;

   always_ff @(posedge clock) begin
      if (!resetn)
         state <= FETCH;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      pend_set  = 1'b0;

      case (pcsource)
         2'b10:   tgt_raw = rpc;
         2'b11:   tgt_raw = jpc;
         default: tgt_raw = bpc;
      endcase
      target = tgt_raw & 32'hFFFF_FFFC;
      pc4    = pc + 32'd4;

      // reset gates the request combinationally so no transfer can start in a reset cycle
      imem_req = resetn & (state == FETCH);
      complete = imem_req & imem_ready;
      consume  = dvalid & ~id_stall;
      accept   = ~dvalid | ~id_stall;
      redirect = consume & (pcsource != 2'b00);

      // a completing slot is dropped when squashing and a redirect applies to it now or is pending
      discard   = SQUASH & complete & (redirect | redir_pend);
      load_mem  = complete & accept & ~discard;
      to_hold   = complete & ~accept & ~discard;
      load_hold = (state == HOLD) & ~id_stall & ~(SQUASH & redirect);

      case (state)
         FETCH: begin
            if (complete) begin
               if (redirect)
                  pc_nxt = target;
               else if (redir_pend)
                  pc_nxt = redir_tgt;
               else
                  pc_nxt = pc4;
               if (to_hold)
                  state_nxt = HOLD;
            end else if (redirect) begin
               // address must not change under an in-flight request
               pend_set = 1'b1;
            end
         end
         HOLD: begin
            if (!id_stall) begin
               state_nxt = FETCH;
               if (redirect)
                  pc_nxt = target;
            end
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         pc         <= RESET_PC;
         redir_pend <= 1'b0;
         dvalid     <= 1'b0;
         dinst      <= NOP_INST;
         dpc4       <= 32'd0;
      end else begin
         pc <= pc_nxt;
         if (complete)
            redir_pend <= 1'b0;
         else if (pend_set)
            redir_pend <= 1'b1;

         if (load_mem) begin
            dinst  <= imem_rdata;
            dpc4   <= pc4;
            dvalid <= 1'b1;
         end else if (load_hold) begin
            dinst  <= hold_inst_p1;
            dpc4   <= hold_pc4_p1;
            dvalid <= 1'b1;
         end else if (consume) begin
            dinst  <= NOP_INST;
            dvalid <= 1'b0;
         end
      end
   end

   // hold buffer and pending target are pure data; emptiness is tracked by state / redir_pend
   always_ff @(posedge clock) begin
      if (pend_set)
         redir_tgt <= target;
      if (to_hold) begin
         hold_inst_p1 <= imem_rdata;
         hold_pc4_p1  <= pc4;
      end
   end

   assign imem_addr = pc;
   assign if_busy   = ((state == FETCH) & ~imem_ready) | (state == HOLD);

endmodule
